decode_execute_unit: RTL and testbench

//  RV64I decode + control + execute block between Fetch and the register file/Dmem of the core.

---
 rtl/rv64_pkg.sv | 82 ++++++++
 rtl/rv_alu_core.sv | 59 +++++
 rtl/decode_execute_unit.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_decode_execute_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/rv64_pkg.sv
// Shared RV64I decode vocabulary: opcodes, funct3 codes, ALU operations and immediate formats.
// gen_imm builds the sign-extended 64-bit immediate for each instruction format.
package rv64_pkg;

  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_SLL   = 4'h2,
    ALU_SLT   = 4'h3,
    ALU_SLTU  = 4'h4,
    ALU_XOR   = 4'h5,
    ALU_SRL   = 4'h6,
    ALU_SRA   = 4'h7,
    ALU_OR    = 4'h8,
    ALU_AND   = 4'h9,
    ALU_ADDW  = 4'ha,
    ALU_SUBW  = 4'hb,
    ALU_SLLW  = 4'hc,
    ALU_SRLW  = 4'hd,
    ALU_SRAW  = 4'he,
    ALU_PASSB = 4'hf
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_type_e;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } b_sel_e;

  function automatic logic [63:0] gen_imm(input logic [31:0] instr, input imm_type_e t);
    logic [63:0] imm;
    case (t)
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'h000};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = 64'h0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/rv_alu_core.sv
// Combinational RV64I ALU; W-suffixed ops work on the low 32 bits and sign-extend bit 31.
module rv_alu_core
  import rv64_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  alu_op_e               i_alu_op,
  output logic [DATA_WIDTH-1:0] o_result
);

  logic [31:0] w_word;
  logic [5:0]  w_shamt;
  logic [4:0]  w_shamt_w;

  assign w_shamt   = i_b[5:0];
  assign w_shamt_w = i_b[4:0];

  always_comb begin
    w_word   = 32'h0;
    o_result = {DATA_WIDTH{1'b0}};
    case (i_alu_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SLT:   o_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_result = {{(DATA_WIDTH-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_ADDW: begin
        w_word   = i_a[31:0] + i_b[31:0];
        o_result = {{(DATA_WIDTH-32){w_word[31]}}, w_word};
      end
      ALU_SUBW: begin
        w_word   = i_a[31:0] - i_b[31:0];
        o_result = {{(DATA_WIDTH-32){w_word[31]}}, w_word};
      end
      ALU_SLLW: begin
        w_word   = i_a[31:0] << w_shamt_w;
        o_result = {{(DATA_WIDTH-32){w_word[31]}}, w_word};
      end
      ALU_SRLW: begin
        w_word   = i_a[31:0] >> w_shamt_w;
        o_result = {{(DATA_WIDTH-32){w_word[31]}}, w_word};
      end
      ALU_SRAW: begin
        w_word   = $unsigned($signed(i_a[31:0]) >>> w_shamt_w);
        o_result = {{(DATA_WIDTH-32){w_word[31]}}, w_word};
      end
      ALU_PASSB: o_result = i_b;
      default:   o_result = {DATA_WIDTH{1'b0}};
    endcase
  end

endmodule

// File: rtl/decode_execute_unit.sv
// RV64I decode/control/execute stage: decodes the fetched instruction, runs the ALU and
// branch compare, and registers every result once at the ID/EX->MEM boundary.
module decode_execute_unit
  import rv64_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_instr_valid,
  input  logic [31:0]           i_if_instr,
  input  logic [ADDR_WIDTH-1:0] i_if_address,
  output logic [4:0]            o_rs1_addr,
  output logic [4:0]            o_rs2_addr,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_out_valid,
  output logic [4:0]            o_rd_addr,
  output logic [DATA_WIDTH-1:0] o_alu_result,
  output logic [DATA_WIDTH-1:0] o_store_data,
  output logic                  o_reg_write,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_mem_to_reg,
  output logic [2:0]            o_mem_funct3,
  output logic                  o_branch_taken,
  output logic [ADDR_WIDTH-1:0] o_branch_target,
  output logic                  o_illegal
);

  logic [6:0]            w_opcode;
  logic [2:0]            w_funct3;
  logic [6:0]            w_funct7;
  logic [4:0]            w_rd;
  logic [63:0]           w_imm;
  imm_type_e             w_imm_type;
  alu_op_e               w_alu_op;
  b_sel_e                w_b_sel;
  logic                  w_a_pc;
  logic                  w_reg_write;
  logic                  w_mem_read;
  logic                  w_mem_write;
  logic                  w_mem_to_reg;
  logic                  w_is_branch;
  logic                  w_is_jal;
  logic                  w_is_jalr;
  logic                  w_illegal;
  logic                  w_cond;
  logic                  w_taken;
  logic                  w_rd_write;
  logic [DATA_WIDTH-1:0] w_op_a;
  logic [DATA_WIDTH-1:0] w_op_b;
  logic [DATA_WIDTH-1:0] w_alu_out;
  logic [ADDR_WIDTH-1:0] w_target;

  logic                  r_out_valid;
  logic [4:0]            r_rd_addr;
  logic [DATA_WIDTH-1:0] r_alu_result;
  logic [DATA_WIDTH-1:0] r_store_data;
  logic                  r_reg_write;
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic                  r_mem_to_reg;
  logic [2:0]            r_mem_funct3;
  logic                  r_branch_taken;
  logic [ADDR_WIDTH-1:0] r_branch_target;
  logic                  r_illegal;

  assign w_opcode   = i_if_instr[6:0];
  assign w_rd       = i_if_instr[11:7];
  assign w_funct3   = i_if_instr[14:12];
  assign w_funct7   = i_if_instr[31:25];
  assign o_rs1_addr = i_if_instr[19:15];
  assign o_rs2_addr = i_if_instr[24:20];
  assign w_imm      = gen_imm(i_if_instr, w_imm_type);

  always_comb begin
    w_imm_type   = IMM_I;
    w_alu_op     = ALU_ADD;
    w_b_sel      = B_IMM;
    w_a_pc       = 1'b0;
    w_reg_write  = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_to_reg = 1'b0;
    w_is_branch  = 1'b0;
    w_is_jal     = 1'b0;
    w_is_jalr    = 1'b0;
    w_illegal    = 1'b0;
    case (w_opcode)
      OPC_LUI: begin
        w_imm_type  = IMM_U;
        w_alu_op    = ALU_PASSB;
        w_reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        w_imm_type  = IMM_U;
        w_a_pc      = 1'b1;
        w_reg_write = 1'b1;
      end
      // Link value PC+4 comes out of the ALU; the redirect address is formed separately.
      OPC_JAL: begin
        w_imm_type  = IMM_J;
        w_a_pc      = 1'b1;
        w_b_sel     = B_FOUR;
        w_reg_write = 1'b1;
        w_is_jal    = 1'b1;
      end
      OPC_JALR: begin
        w_a_pc      = 1'b1;
        w_b_sel     = B_FOUR;
        w_reg_write = 1'b1;
        w_is_jalr   = 1'b1;
        w_illegal   = (w_funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        w_imm_type  = IMM_B;
        w_b_sel     = B_RS2;
        w_alu_op    = ALU_SUB;
        w_is_branch = 1'b1;
        w_illegal   = (w_funct3 == 3'b010) || (w_funct3 == 3'b011);
      end
      OPC_LOAD: begin
        w_reg_write  = 1'b1;
        w_mem_read   = 1'b1;
        w_mem_to_reg = 1'b1;
        w_illegal    = (w_funct3 == 3'b111);
      end
      OPC_STORE: begin
        w_imm_type  = IMM_S;
        w_mem_write = 1'b1;
        w_illegal   = w_funct3[2];
      end
      OPC_OP_IMM: begin
        w_reg_write = 1'b1;
        case (w_funct3)
          F3_ADD:  w_alu_op = ALU_ADD;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_SLTU: w_alu_op = ALU_SLTU;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          F3_SLL: begin
            w_alu_op  = ALU_SLL;
            w_illegal = (i_if_instr[31:26] != 6'b000000);
          end
          F3_SR: begin
            w_alu_op  = i_if_instr[30] ? ALU_SRA : ALU_SRL;
            w_illegal = (i_if_instr[31:26] != 6'b000000) && (i_if_instr[31:26] != 6'b010000);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_OP: begin
        w_reg_write = 1'b1;
        w_b_sel     = B_RS2;
        w_illegal   = (w_funct7 != F7_BASE) &&
                      !((w_funct7 == F7_ALT) && ((w_funct3 == F3_ADD) || (w_funct3 == F3_SR)));
        case (w_funct3)
          F3_ADD:  w_alu_op = i_if_instr[30] ? ALU_SUB : ALU_ADD;
          F3_SLL:  w_alu_op = ALU_SLL;
          F3_SLT:  w_alu_op = ALU_SLT;
          F3_SLTU: w_alu_op = ALU_SLTU;
          F3_XOR:  w_alu_op = ALU_XOR;
          F3_SR:   w_alu_op = i_if_instr[30] ? ALU_SRA : ALU_SRL;
          F3_OR:   w_alu_op = ALU_OR;
          F3_AND:  w_alu_op = ALU_AND;
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM_32: begin
        w_reg_write = 1'b1;
        case (w_funct3)
          F3_ADD:  w_alu_op = ALU_ADDW;
          F3_SLL: begin
            w_alu_op  = ALU_SLLW;
            w_illegal = (w_funct7 != F7_BASE);
          end
          F3_SR: begin
            w_alu_op  = i_if_instr[30] ? ALU_SRAW : ALU_SRLW;
            w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      OPC_OP_32: begin
        w_reg_write = 1'b1;
        w_b_sel     = B_RS2;
        case (w_funct3)
          F3_ADD: begin
            w_alu_op  = i_if_instr[30] ? ALU_SUBW : ALU_ADDW;
            w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          F3_SLL: begin
            w_alu_op  = ALU_SLLW;
            w_illegal = (w_funct7 != F7_BASE);
          end
          F3_SR: begin
            w_alu_op  = i_if_instr[30] ? ALU_SRAW : ALU_SRLW;
            w_illegal = (w_funct7 != F7_BASE) && (w_funct7 != F7_ALT);
          end
          default: w_illegal = 1'b1;
        endcase
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_op_a = w_a_pc ? i_if_address : i_rs1_data;
    case (w_b_sel)
      B_RS2:   w_op_b = i_rs2_data;
      B_IMM:   w_op_b = w_imm;
      B_FOUR:  w_op_b = 64'd4;
      default: w_op_b = w_imm;
    endcase
  end

  rv_alu_core #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .i_alu_op (w_alu_op),
    .o_result (w_alu_out)
  );

  always_comb begin
    case (w_funct3)
      F3_BEQ:  w_cond = (i_rs1_data == i_rs2_data);
      F3_BNE:  w_cond = (i_rs1_data != i_rs2_data);
      F3_BLT:  w_cond = ($signed(i_rs1_data) < $signed(i_rs2_data));
      F3_BGE:  w_cond = ($signed(i_rs1_data) >= $signed(i_rs2_data));
      F3_BLTU: w_cond = (i_rs1_data < i_rs2_data);
      F3_BGEU: w_cond = (i_rs1_data >= i_rs2_data);
      default: w_cond = 1'b0;
    endcase
    if (w_is_jalr) begin
      w_target = (i_rs1_data + w_imm) & ~64'd1;
    end else begin
      w_target = i_if_address + w_imm;
    end
  end

  // An illegal encoding suppresses every side effect; writes to x0 are dropped.
  assign w_taken    = !w_illegal && ((w_is_branch && w_cond) || w_is_jal || w_is_jalr);
  assign w_rd_write = !w_illegal && w_reg_write && (w_rd != 5'd0);

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_instr_valid) begin
      r_out_valid     <= 1'b0;
      r_rd_addr       <= 5'd0;
      r_alu_result    <= {DATA_WIDTH{1'b0}};
      r_store_data    <= {DATA_WIDTH{1'b0}};
      r_reg_write     <= 1'b0;
      r_mem_read      <= 1'b0;
      r_mem_write     <= 1'b0;
      r_mem_to_reg    <= 1'b0;
      r_mem_funct3    <= 3'd0;
      r_branch_taken  <= 1'b0;
      r_branch_target <= {ADDR_WIDTH{1'b0}};
      r_illegal       <= 1'b0;
    end else begin
      r_out_valid     <= 1'b1;
      r_rd_addr       <= w_rd;
      r_alu_result    <= w_alu_out;
      r_store_data    <= (w_mem_write && !w_illegal) ? i_rs2_data : {DATA_WIDTH{1'b0}};
      r_reg_write     <= w_rd_write;
      r_mem_read      <= w_mem_read && !w_illegal;
      r_mem_write     <= w_mem_write && !w_illegal;
      r_mem_to_reg    <= w_mem_to_reg && !w_illegal;
      r_mem_funct3    <= ((w_mem_read || w_mem_write) && !w_illegal) ? w_funct3 : 3'd0;
      r_branch_taken  <= w_taken;
      r_branch_target <= w_taken ? w_target : {ADDR_WIDTH{1'b0}};
      r_illegal       <= w_illegal;
    end
  end

  assign o_out_valid     = r_out_valid;
  assign o_rd_addr       = r_rd_addr;
  assign o_alu_result    = r_alu_result;
  assign o_store_data    = r_store_data;
  assign o_reg_write     = r_reg_write;
  assign o_mem_read      = r_mem_read;
  assign o_mem_write     = r_mem_write;
  assign o_mem_to_reg    = r_mem_to_reg;
  assign o_mem_funct3    = r_mem_funct3;
  assign o_branch_taken  = r_branch_taken;
  assign o_branch_target = r_branch_target;
  assign o_illegal       = r_illegal;

endmodule

// File: tb/tb_decode_execute_unit.sv
// Directed-vector bench for decode_execute_unit with hand-computed expectations.
module tb_decode_execute_unit;

  logic        clk;
  logic        reset;
  logic        instr_valid;
  logic [31:0] if_instr;
  logic [63:0] if_address;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [63:0] rs1_data;
  logic [63:0] rs2_data;
  logic        out_valid;
  logic [4:0]  rd_addr;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic [2:0]  mem_funct3;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        illegal;

  int n_vec  = 0;
  int n_miss = 0;

  decode_execute_unit dut (
    .i_clk           (clk),
    .i_reset         (reset),
    .i_instr_valid   (instr_valid),
    .i_if_instr      (if_instr),
    .i_if_address    (if_address),
    .o_rs1_addr      (rs1_addr),
    .o_rs2_addr      (rs2_addr),
    .i_rs1_data      (rs1_data),
    .i_rs2_data      (rs2_data),
    .o_out_valid     (out_valid),
    .o_rd_addr       (rd_addr),
    .o_alu_result    (alu_result),
    .o_store_data    (store_data),
    .o_reg_write     (reg_write),
    .o_mem_read      (mem_read),
    .o_mem_write     (mem_write),
    .o_mem_to_reg    (mem_to_reg),
    .o_mem_funct3    (mem_funct3),
    .o_branch_taken  (branch_taken),
    .o_branch_target (branch_target),
    .o_illegal       (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one instruction between edges, then sample just after the capturing edge.
  task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] pc,
                      input logic [63:0] a, input logic [63:0] b);
    @(negedge clk);
    instr_valid = v;
    if_instr    = ins;
    if_address  = pc;
    rs1_data    = a;
    rs2_data    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; instr_valid = 1'b0; if_instr = 32'h0; if_address = 64'h0;
    rs1_data = 64'h0; rs2_data = 64'h0;

    // Reset beats a valid instruction presented at the same edge
    step(1'b1, 32'h00500093, 64'h0, 64'h0, 64'h0);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_rd", {59'd0, rd_addr}, 64'd0);
    chk("rst_alu", alu_result, 64'd0);
    chk("rst_rw", {63'd0, reg_write}, 64'd0);
    reset = 1'b0;

    // addi x1,x0,5
    step(1'b1, 32'h00500093, 64'h0, 64'h0, 64'h0);
    chk("addi_valid", {63'd0, out_valid}, 64'd1);
    chk("addi_rd", {59'd0, rd_addr}, 64'd1);
    chk("addi_alu", alu_result, 64'd5);
    chk("addi_rw", {63'd0, reg_write}, 64'd1);
    chk("addi_mem", {62'd0, mem_read, mem_write}, 64'd0);

    // Register-file addresses follow if_instr combinationally
    @(negedge clk);
    if_instr = 32'h402081B3;
    #1;
    chk("rs1_addr", {59'd0, rs1_addr}, 64'd1);
    chk("rs2_addr", {59'd0, rs2_addr}, 64'd2);

    // sub x3,x1,x2
    step(1'b1, 32'h402081B3, 64'h0, 64'd10, 64'd3);
    chk("sub_alu", alu_result, 64'd7);
    chk("sub_rd", {59'd0, rd_addr}, 64'd3);
    chk("sub_rw", {63'd0, reg_write}, 64'd1);

    // ld x5,8(x2)
    step(1'b1, 32'h00813283, 64'h0, 64'h1000, 64'h0);
    chk("ld_alu", alu_result, 64'h1008);
    chk("ld_strobes", {61'd0, reg_write, mem_read, mem_to_reg}, 64'h7);
    chk("ld_f3", {61'd0, mem_funct3}, 64'd3);
    chk("ld_rd", {59'd0, rd_addr}, 64'd5);

    // sd x5,16(x2)
    step(1'b1, 32'h00513823, 64'h0, 64'h1000, 64'hAB);
    chk("sd_alu", alu_result, 64'h1010);
    chk("sd_data", store_data, 64'hAB);
    chk("sd_strobes", {61'd0, mem_write, reg_write, mem_read}, 64'h4);

    // addw x1,x2,x3 overflows into the sign of the 32-bit word
    step(1'b1, 32'h003100BB, 64'h0, 64'h7FFFFFFF, 64'd1);
    chk("addw_alu", alu_result, 64'hFFFFFFFF80000000);

    // sllw x1,x2,x3 by 31
    step(1'b1, 32'h003110BB, 64'h0, 64'd1, 64'd31);
    chk("sllw_alu", alu_result, 64'hFFFFFFFF80000000);

    // srai x1,x2,4 (imm[10] selects arithmetic)
    step(1'b1, 32'h40415093, 64'h0, 64'h8000000000000010, 64'h0);
    chk("srai_alu", alu_result, 64'hF800000000000001);

    // Unknown opcode
    step(1'b1, 32'h0000007F, 64'h0, 64'h0, 64'h0);
    chk("ill_flag", {63'd0, illegal}, 64'd1);
    chk("ill_valid", {63'd0, out_valid}, 64'd1);
    chk("ill_strobes", {59'd0, reg_write, mem_read, mem_write, mem_to_reg, branch_taken}, 64'd0);

    // OP with funct7=0000001 is not part of RV64I
    step(1'b1, 32'h022080B3, 64'h0, 64'd1, 64'd1);
    chk("ill_f7", {63'd0, illegal}, 64'd1);
    chk("ill_f7_rw", {63'd0, reg_write}, 64'd0);

    // beq x1,x2,+8 taken
    step(1'b1, 32'h00208463, 64'h100, 64'd5, 64'd5);
    chk("beq_taken", {63'd0, branch_taken}, 64'd1);
    chk("beq_target", branch_target, 64'h108);
    chk("beq_rw", {63'd0, reg_write}, 64'd0);

    // bne with equal operands is not taken
    step(1'b1, 32'h00209463, 64'h100, 64'd5, 64'd5);
    chk("bne_taken", {63'd0, branch_taken}, 64'd0);

    // blt signed -1 < 1 taken, bltu unsigned not taken
    step(1'b1, 32'h0020C463, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    chk("blt_taken", {63'd0, branch_taken}, 64'd1);
    step(1'b1, 32'h0020E463, 64'h100, 64'hFFFFFFFFFFFFFFFF, 64'd1);
    chk("bltu_taken", {63'd0, branch_taken}, 64'd0);

    // jal x1,+16
    step(1'b1, 32'h010000EF, 64'h200, 64'h0, 64'h0);
    chk("jal_link", alu_result, 64'h204);
    chk("jal_target", branch_target, 64'h210);
    chk("jal_ctl", {62'd0, branch_taken, reg_write}, 64'h3);

    // jalr x1,4(x2) clears bit 0 of the target
    step(1'b1, 32'h004100E7, 64'h400, 64'h301, 64'h0);
    chk("jalr_link", alu_result, 64'h404);
    chk("jalr_target", branch_target, 64'h304);
    chk("jalr_taken", {63'd0, branch_taken}, 64'd1);

    // lui / auipc
    step(1'b1, 32'h123450B7, 64'h0, 64'hDEAD, 64'h0);
    chk("lui_alu", alu_result, 64'h12345000);
    step(1'b1, 32'h800000B7, 64'h0, 64'h0, 64'h0);
    chk("lui_neg", alu_result, 64'hFFFFFFFF80000000);
    step(1'b1, 32'h00001097, 64'h1000, 64'h0, 64'h0);
    chk("auipc_alu", alu_result, 64'h2000);

    // rd=x0 never writes
    step(1'b1, 32'h00100013, 64'h0, 64'h0, 64'h0);
    chk("x0_rw", {63'd0, reg_write}, 64'd0);
    chk("x0_alu", alu_result, 64'd1);

    // No valid instruction
    step(1'b0, 32'h00500093, 64'h0, 64'h0, 64'h0);
    chk("idle_valid", {63'd0, out_valid}, 64'd0);
    chk("idle_rw", {63'd0, reg_write}, 64'd0);

    // Reset after activity clears the outputs again
    step(1'b1, 32'h00813283, 64'h0, 64'h1000, 64'h0);
    reset = 1'b1;
    step(1'b1, 32'h00813283, 64'h0, 64'h1000, 64'h0);
    chk("rst2_valid", {63'd0, out_valid}, 64'd0);
    chk("rst2_alu", alu_result, 64'd0);
    chk("rst2_strobes", {60'd0, mem_read, mem_to_reg, reg_write, mem_write}, 64'd0);
    chk("rst2_f3", {61'd0, mem_funct3}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
